// File: rtl/ucode_sequencer_pkg.sv
`default_nettype none
// Shared encodings for the microcode sequencer: FSM states, ROM word layout,
// operand-selector codes and the macro-marker bit.
package ucode_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PASS  = 3'd1,
    ST_ENTER = 3'd2,
    ST_RUN   = 3'd3,
    ST_EXIT  = 3'd4
  } state_t;

  localparam int OP_W  = 8;
  localparam int REG_W = 4;
  localparam int SEL_W = REG_W + 1;

  // ROM word layout, LSB first: last, write, rs2_sel, rs1_sel, rd_sel, op
  localparam int LAST_OFS  = 0;
  localparam int WRITE_OFS = 1;
  localparam int RS2_OFS   = 2;
  localparam int RS1_OFS   = RS2_OFS + SEL_W;
  localparam int RD_OFS    = RS1_OFS + SEL_W;
  localparam int OP_OFS    = RD_OFS + SEL_W;
  localparam int WORD_W    = OP_OFS + OP_W;

  localparam logic             SEL_LIT   = 1'b0;
  localparam logic             SEL_MACRO = 1'b1;
  localparam logic [SEL_W-1:0] SEL_M     = {SEL_MACRO, {REG_W{1'b0}}};

  localparam int MACRO_BIT = 7;

  typedef struct packed {
    logic             valid;
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             write;
    logic             last;
    logic             flag;
  } uop_out_t;

  function automatic logic [SEL_W-1:0] sel_lit(input logic [REG_W-1:0] idx);
    return {SEL_LIT, idx};
  endfunction

  function automatic logic [WORD_W-1:0] mk_word(
    input logic [OP_W-1:0]  op,
    input logic [SEL_W-1:0] rd,
    input logic [SEL_W-1:0] rs1,
    input logic [SEL_W-1:0] rs2,
    input logic             wr,
    input logic             last
  );
    logic [WORD_W-1:0] w;
    w = '0;
    w[OP_OFS +: OP_W]   = op;
    w[RD_OFS +: SEL_W]  = rd;
    w[RS1_OFS +: SEL_W] = rs1;
    w[RS2_OFS +: SEL_W] = rs2;
    w[WRITE_OFS]        = wr;
    w[LAST_OFS]         = last;
    return w;
  endfunction

  function automatic logic [REG_W-1:0] resolve_sel(
    input logic [SEL_W-1:0] sel,
    input logic [REG_W-1:0] macro_idx
  );
    return (sel[SEL_W-1] == SEL_MACRO) ? macro_idx : sel[REG_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ucode_rom.sv
`default_nettype none
// Combinational microcode store: 16-entry macro entry table plus the
// 2**UPC_W-word micro-op ROM.
module ucode_rom
  import ucode_sequencer_pkg::*;
#(
  parameter int UPC_W = 6
) (
  input  logic [3:0]        entry_idx_i,
  output logic [UPC_W-1:0]  entry_upc_o,
  input  logic [UPC_W-1:0]  upc_i,
  output logic [WORD_W-1:0] word_o
);

  // Unprogrammed words never terminate, so a stray entry trips the watchdog.
  localparam logic [WORD_W-1:0] FILL_WORD =
    mk_word(8'h7F, sel_lit(4'h0), sel_lit(4'h0), sel_lit(4'h0), 1'b0, 1'b0);

  always_comb begin
    entry_upc_o = '0;
    case (entry_idx_i)
      4'd1:    entry_upc_o = UPC_W'(4);
      4'd2:    entry_upc_o = UPC_W'(32);
      4'd3:    entry_upc_o = UPC_W'(62);
      4'd4:    entry_upc_o = UPC_W'(8);
      default: entry_upc_o = '0;
    endcase
  end

  always_comb begin
    word_o = FILL_WORD;
    case (upc_i)
      UPC_W'(0): word_o = mk_word(8'h40, SEL_M, SEL_M, SEL_M, 1'b1, 1'b1);
      UPC_W'(4): word_o = mk_word(8'h50, sel_lit(4'hE), SEL_M, sel_lit(4'h1), 1'b1, 1'b0);
      UPC_W'(5): word_o = mk_word(8'h51, sel_lit(4'hD), sel_lit(4'hE), SEL_M, 1'b0, 1'b0);
      UPC_W'(6): word_o = mk_word(8'h52, SEL_M, sel_lit(4'hD), sel_lit(4'hE), 1'b1, 1'b1);
      UPC_W'(8): word_o = mk_word(8'h60, sel_lit(4'h2), SEL_M, sel_lit(4'h3), 1'b1, 1'b0);
      UPC_W'(9): word_o = mk_word(8'h61, sel_lit(4'h4), sel_lit(4'hE), SEL_M, 1'b1, 1'b1);
      default:   word_o = FILL_WORD;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ucode_sequencer.sv
`default_nettype none
// Microcode sequencer: passes plain ops through with one cycle of latency and
// expands bit7-marked macros into ROM micro-op sequences on a ghost register file.
module ucode_sequencer
  import ucode_sequencer_pkg::*;
#(
  parameter int UPC_W    = 6,
  parameter int MAX_UOPS = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [7:0] opcode,
  input  logic [3:0] macro_rd,
  input  logic [3:0] macro_rs1,
  input  logic [3:0] macro_rs2,
  input  logic       pipe_stall,
  output logic       uop_valid,
  output logic [7:0] uop_op,
  output logic [3:0] uop_rd,
  output logic [3:0] uop_rs1,
  output logic [3:0] uop_rs2,
  output logic       uop_write,
  output logic       ucode_flag,
  output logic       ucode_err
);

  localparam int              CNT_W     = $clog2(MAX_UOPS + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_UOPS);

  state_t            state_q, state_d;
  logic [UPC_W-1:0]  upc_q, upc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              enter_q, enter_d;
  logic              err_q, err_d;
  logic [REG_W-1:0]  mrd_q, mrd_d, mrs1_q, mrs1_d, mrs2_q, mrs2_d;
  uop_out_t          out_q, out_d, rom_uop;
  logic [UPC_W-1:0]  rom_addr, entry_upc;
  logic [WORD_W-1:0] rom_word;

  assign instr_ready = ((state_q == ST_IDLE) || (state_q == ST_PASS)) && !pipe_stall;
  assign cnt_inc     = cnt_q + CNT_W'(1);
  // In RUN the output register is refilled with the word after the one on display.
  assign rom_addr    = (state_q == ST_RUN) ? upc_q + UPC_W'(1) : upc_q;

  ucode_rom #(.UPC_W(UPC_W)) u_rom (
    .entry_idx_i (opcode[3:0]),
    .entry_upc_o (entry_upc),
    .upc_i       (rom_addr),
    .word_o      (rom_word)
  );

  always_comb begin
    rom_uop       = '0;
    rom_uop.valid = 1'b1;
    rom_uop.op    = rom_word[OP_OFS +: OP_W];
    rom_uop.rd    = resolve_sel(rom_word[RD_OFS +: SEL_W], mrd_q);
    rom_uop.rs1   = resolve_sel(rom_word[RS1_OFS +: SEL_W], mrs1_q);
    rom_uop.rs2   = resolve_sel(rom_word[RS2_OFS +: SEL_W], mrs2_q);
    rom_uop.write = rom_word[WRITE_OFS];
    rom_uop.last  = rom_word[LAST_OFS];
    rom_uop.flag  = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    upc_d   = upc_q;
    cnt_d   = cnt_q;
    enter_d = enter_q;
    err_d   = err_q;
    mrd_d   = mrd_q;
    mrs1_d  = mrs1_q;
    mrs2_d  = mrs2_q;
    out_d   = out_q;
    case (state_q)
      ST_IDLE, ST_PASS: begin
        if (!pipe_stall) begin
          out_d   = '0;
          state_d = ST_IDLE;
          if (instr_valid) begin
            if (opcode[MACRO_BIT]) begin
              state_d    = ST_ENTER;
              upc_d      = entry_upc;
              cnt_d      = '0;
              enter_d    = 1'b0;
              mrd_d      = macro_rd;
              mrs1_d     = macro_rs1;
              mrs2_d     = macro_rs2;
              out_d.flag = 1'b1;
            end else begin
              state_d     = ST_PASS;
              out_d.valid = 1'b1;
              out_d.op    = opcode;
              out_d.rd    = macro_rd;
              out_d.rs1   = macro_rs1;
              out_d.rs2   = macro_rs2;
              out_d.write = 1'b1;
            end
          end
        end
      end
      ST_ENTER: begin
        enter_d = 1'b1;
        if (enter_q) begin
          state_d = ST_RUN;
          out_d   = rom_uop;
        end
      end
      ST_RUN: begin
        if (!pipe_stall) begin
          upc_d = upc_q + UPC_W'(1);
          cnt_d = cnt_inc;
          if (out_q.last) begin
            state_d = ST_EXIT;
            out_d   = '0;
          end else if (cnt_inc == CNT_LIMIT) begin
            state_d = ST_EXIT;
            err_d   = 1'b1;
            out_d   = '0;
          end else begin
            out_d = rom_uop;
          end
        end
      end
      ST_EXIT: begin
        state_d = ST_IDLE;
        out_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        out_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      upc_q   <= '0;
      cnt_q   <= '0;
      enter_q <= 1'b0;
      err_q   <= 1'b0;
      mrd_q   <= '0;
      mrs1_q  <= '0;
      mrs2_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      cnt_q   <= cnt_d;
      enter_q <= enter_d;
      err_q   <= err_d;
      mrd_q   <= mrd_d;
      mrs1_q  <= mrs1_d;
      mrs2_q  <= mrs2_d;
      out_q   <= out_d;
    end
  end

  assign uop_valid  = out_q.valid;
  assign uop_op     = out_q.op;
  assign uop_rd     = out_q.rd;
  assign uop_rs1    = out_q.rs1;
  assign uop_rs2    = out_q.rs2;
  assign uop_write  = out_q.write;
  assign ucode_flag = out_q.flag;
  assign ucode_err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ucode_sequencer.sv
`default_nettype none
// Self-checking bench for ucode_sequencer: randomized passthrough and macro
// traffic compared against a sequence-level reference model.
module tb_ucode_sequencer;

  localparam int MAX_UOPS = 32;
  localparam int DEPTH    = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [7:0] opcode = '0;
  logic [3:0] macro_rd = '0, macro_rs1 = '0, macro_rs2 = '0;
  logic       pipe_stall = 1'b0;
  logic       uop_valid, uop_write, ucode_flag, ucode_err;
  logic [7:0] uop_op;
  logic [3:0] uop_rd, uop_rs1, uop_rs2;

  ucode_sequencer #(.UPC_W(6), .MAX_UOPS(MAX_UOPS)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .macro_rd(macro_rd), .macro_rs1(macro_rs1), .macro_rs2(macro_rs2),
    .pipe_stall(pipe_stall), .uop_valid(uop_valid), .uop_op(uop_op), .uop_rd(uop_rd),
    .uop_rs1(uop_rs1), .uop_rs2(uop_rs2), .uop_write(uop_write),
    .ucode_flag(ucode_flag), .ucode_err(ucode_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic m_err = 1'b0;

  logic [23:0] obs;
  logic [3:0]  obs_ctl;
  assign obs     = {uop_valid, uop_op, uop_rd, uop_rs1, uop_rs2, uop_write, ucode_flag, ucode_err};
  assign obs_ctl = {uop_valid, uop_write, ucode_flag, ucode_err};

  // Expected microcode image: op, selectors (bit4 = use macro operand), write, last.
  logic [7:0] r_op   [DEPTH];
  logic [4:0] r_rd   [DEPTH];
  logic [4:0] r_rs1  [DEPTH];
  logic [4:0] r_rs2  [DEPTH];
  logic       r_wr   [DEPTH];
  logic       r_last [DEPTH];
  int         e_upc  [16];

  typedef struct packed {
    logic [7:0] op;
    logic [3:0] rd, rs1, rs2;
    logic       wr;
  } uop_t;

  task automatic set_word(input int a, input logic [7:0] op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic wr, input logic last);
    r_op[a] = op; r_rd[a] = rd; r_rs1[a] = rs1; r_rs2[a] = rs2;
    r_wr[a] = wr; r_last[a] = last;
  endtask

  task automatic init_model();
    for (int a = 0; a < DEPTH; a++) set_word(a, 8'h7F, 5'h00, 5'h00, 5'h00, 1'b0, 1'b0);
    set_word(0, 8'h40, 5'h10, 5'h10, 5'h10, 1'b1, 1'b1);
    set_word(4, 8'h50, 5'h0E, 5'h10, 5'h01, 1'b1, 1'b0);
    set_word(5, 8'h51, 5'h0D, 5'h0E, 5'h10, 1'b0, 1'b0);
    set_word(6, 8'h52, 5'h10, 5'h0D, 5'h0E, 1'b1, 1'b1);
    set_word(8, 8'h60, 5'h02, 5'h10, 5'h03, 1'b1, 1'b0);
    set_word(9, 8'h61, 5'h04, 5'h0E, 5'h10, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) e_upc[i] = 0;
    e_upc[1] = 4; e_upc[2] = 32; e_upc[3] = 62; e_upc[4] = 8;
  endtask

  function automatic logic [3:0] pick(input logic [4:0] sel, input logic [3:0] m);
    return sel[4] ? m : sel[3:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; pipe_stall = 1'b0; instr_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== 24'h0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected %h", obs, 24'h0);
    end
    checks++;
    if (instr_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got %b expected 1", instr_ready);
    end
    #3 rst = 1'b1;
    step();
  endtask

  task automatic test_passthrough();
    logic       e_valid;
    logic [7:0] e_op;
    logic [3:0] e_rd, e_rs1, e_rs2;
    logic [31:0] r;
    // Directed single op
    pipe_stall = 1'b0; instr_valid = 1'b1; opcode = 8'h12;
    macro_rd = 4'd3; macro_rs1 = 4'd4; macro_rs2 = 4'd5;
    checks++;
    if (instr_ready !== 1'b1) begin
      failures++;
      $display("FAIL pass_ready: got %b expected 1", instr_ready);
    end
    step();
    instr_valid = 1'b0;
    checks++;
    if (obs !== {1'b1, 8'h12, 4'd3, 4'd4, 4'd5, 1'b1, 1'b0, m_err}) begin
      failures++;
      $display("FAIL pass_directed: got %h expected %h", obs,
               {1'b1, 8'h12, 4'd3, 4'd4, 4'd5, 1'b1, 1'b0, m_err});
    end
    e_valid = 1'b1; e_op = 8'h12; e_rd = 4'd3; e_rs1 = 4'd4; e_rs2 = 4'd5;
    // Random traffic with stalls
    for (int c = 0; c < 200; c++) begin
      r = $urandom;
      pipe_stall  = ($urandom_range(0, 3) == 0);
      instr_valid = r[31];
      opcode      = {1'b0, r[6:0]};
      macro_rd = r[11:8]; macro_rs1 = r[15:12]; macro_rs2 = r[19:16];
      #1;
      checks++;
      if (instr_ready !== !pipe_stall) begin
        failures++;
        $display("FAIL pass_ready_rand: got %b expected %b", instr_ready, !pipe_stall);
      end
      checks++;
      if (e_valid) begin
        if (obs !== {1'b1, e_op, e_rd, e_rs1, e_rs2, 1'b1, 1'b0, m_err}) begin
          failures++;
          $display("FAIL pass_rand: got %h expected %h", obs,
                   {1'b1, e_op, e_rd, e_rs1, e_rs2, 1'b1, 1'b0, m_err});
        end
      end else if (obs_ctl !== {3'b000, m_err}) begin
        failures++;
        $display("FAIL pass_rand_idle: got %b expected %b", obs_ctl, {3'b000, m_err});
      end
      if (!pipe_stall) begin
        e_valid = instr_valid;
        e_op = opcode; e_rd = macro_rd; e_rs1 = macro_rs1; e_rs2 = macro_rs2;
      end
      step();
    end
    instr_valid = 1'b0; pipe_stall = 1'b0;
    step();
    checks++;
    if (obs_ctl !== {3'b000, m_err}) begin
      failures++;
      $display("FAIL pass_drain: got %b expected %b", obs_ctl, {3'b000, m_err});
    end
  endtask

  task automatic run_macro(input int idx, input logic [3:0] mrd, input logic [3:0] mrs1,
                           input logic [3:0] mrs2, input int stall_pct, input int dir_uop);
    uop_t  q[$];
    uop_t  u;
    logic  abort;
    int    a, held;
    logic [31:0] r;
    // Expected sequence: walk from the entry, wrapping, until last or watchdog
    a = e_upc[idx]; abort = 1'b0;
    for (int n = 0; n < MAX_UOPS; n++) begin
      u.op = r_op[a]; u.wr = r_wr[a];
      u.rd = pick(r_rd[a], mrd); u.rs1 = pick(r_rs1[a], mrs1); u.rs2 = pick(r_rs2[a], mrs2);
      q.push_back(u);
      if (r_last[a]) break;
      if (n == MAX_UOPS - 1) abort = 1'b1;
      a = (a + 1) % DEPTH;
    end

    pipe_stall = 1'b0; instr_valid = 1'b1;
    r = $urandom;
    opcode = {1'b1, r[2:0], idx[3:0]};
    macro_rd = mrd; macro_rs1 = mrs1; macro_rs2 = mrs2;
    #1;
    checks++;
    if (instr_ready !== 1'b1) begin
      failures++;
      $display("FAIL macro_ready: got %b expected 1", instr_ready);
    end
    step();
    for (int e = 0; e < 2; e++) begin
      r = $urandom;
      instr_valid = r[0]; opcode = {1'b0, r[7:1]}; pipe_stall = r[8];
      macro_rd = r[15:12]; macro_rs1 = r[19:16]; macro_rs2 = r[23:20];
      #1;
      checks++;
      if ({obs_ctl, instr_ready} !== {3'b001, m_err, 1'b0}) begin
        failures++;
        $display("FAIL enter_cycle%0d: got %b expected %b", e, {obs_ctl, instr_ready},
                 {3'b001, m_err, 1'b0});
      end
      step();
    end
    for (int i = 0; i < q.size(); i++) begin
      held = 0;
      while (1) begin
        r = $urandom;
        instr_valid = r[0]; opcode = r[15:8];
        macro_rd = r[19:16]; macro_rs1 = r[23:20]; macro_rs2 = r[27:24];
        if (i == dir_uop && held < 4) pipe_stall = 1'b1;
        else if (held >= 8)           pipe_stall = 1'b0;
        else                          pipe_stall = ($urandom_range(0, 99) < stall_pct);
        #1;
        checks++;
        if ({obs, instr_ready} !== {1'b1, q[i].op, q[i].rd, q[i].rs1, q[i].rs2, q[i].wr,
                                    1'b1, m_err, 1'b0}) begin
          failures++;
          $display("FAIL run_uop%0d idx%0d: got %h expected %h", i, idx, {obs, instr_ready},
                   {1'b1, q[i].op, q[i].rd, q[i].rs1, q[i].rs2, q[i].wr, 1'b1, m_err, 1'b0});
        end
        step();
        if (!pipe_stall) break;
        held++;
      end
    end
    if (abort) m_err = 1'b1;
    instr_valid = 1'b0; pipe_stall = $urandom_range(0, 1);
    #1;
    checks++;
    if ({obs_ctl, instr_ready} !== {3'b000, m_err, 1'b0}) begin
      failures++;
      $display("FAIL exit_cycle idx%0d: got %b expected %b", idx, {obs_ctl, instr_ready},
               {3'b000, m_err, 1'b0});
    end
    step();
    pipe_stall = 1'b0;
    #1;
    checks++;
    if ({obs_ctl, instr_ready} !== {3'b000, m_err, 1'b1}) begin
      failures++;
      $display("FAIL after_exit idx%0d: got %b expected %b", idx, {obs_ctl, instr_ready},
               {3'b000, m_err, 1'b1});
    end
  endtask

  task automatic test_macro_basic();
    run_macro(1, 4'h7, 4'h8, 4'h9, 0, -1);
    run_macro(0, 4'hA, 4'hB, 4'hC, 0, -1);
  endtask

  task automatic test_stall();
    run_macro(1, 4'h1, 4'h2, 4'h3, 0, 1);
  endtask

  task automatic test_selector();
    run_macro(4, 4'h5, 4'd9, 4'h6, 0, -1);
  endtask

  task automatic test_wrap();
    run_macro(3, 4'h2, 4'h4, 4'h6, 20, -1);
  endtask

  task automatic test_random_macros();
    int idx;
    for (int k = 0; k < 12; k++) begin
      idx = $urandom_range(0, 5);
      if (idx == 2) idx = 7;
      run_macro(idx, 4'($urandom), 4'($urandom), 4'($urandom), 30, -1);
    end
  endtask

  task automatic test_back_to_back();
    pipe_stall = 1'b0; instr_valid = 1'b1; opcode = 8'h3C;
    macro_rd = 4'h1; macro_rs1 = 4'h2; macro_rs2 = 4'h3;
    step();
    checks++;
    if (obs !== {1'b1, 8'h3C, 4'h1, 4'h2, 4'h3, 1'b1, 1'b0, m_err}) begin
      failures++;
      $display("FAIL b2b_pass: got %h expected %h", obs,
               {1'b1, 8'h3C, 4'h1, 4'h2, 4'h3, 1'b1, 1'b0, m_err});
    end
    run_macro(1, 4'h4, 4'h5, 4'h6, 0, -1);
    run_macro(4, 4'h7, 4'h8, 4'h9, 10, -1);
  endtask

  task automatic test_watchdog();
    run_macro(2, 4'h1, 4'h1, 4'h1, 10, -1);
    checks++;
    if (ucode_err !== 1'b1) begin
      failures++;
      $display("FAIL watchdog_err: got %b expected 1", ucode_err);
    end
    run_macro(1, 4'h3, 4'h3, 4'h3, 0, -1);
    repeat (5) step();
    checks++;
    if (ucode_err !== 1'b1) begin
      failures++;
      $display("FAIL watchdog_sticky: got %b expected 1", ucode_err);
    end
  endtask

  task automatic test_reset_mid_run();
    pipe_stall = 1'b0; instr_valid = 1'b1; opcode = 8'h81;
    macro_rd = 4'h2; macro_rs1 = 4'h3; macro_rs2 = 4'h4;
    step();
    instr_valid = 1'b0;
    repeat (3) step();
    checks++;
    if (obs !== {1'b1, 8'h51, 4'hD, 4'hE, 4'h4, 1'b0, 1'b1, m_err}) begin
      failures++;
      $display("FAIL midrun_uop2: got %h expected %h", obs,
               {1'b1, 8'h51, 4'hD, 4'hE, 4'h4, 1'b0, 1'b1, m_err});
    end
    #1 rst = 1'b0;
    #1;
    m_err = 1'b0;
    checks++;
    if (obs !== 24'h0) begin
      failures++;
      $display("FAIL midrun_async: got %h expected %h", obs, 24'h0);
    end
    #1 rst = 1'b1;
    step();
    checks++;
    if ({obs, instr_ready} !== {24'h0, 1'b1}) begin
      failures++;
      $display("FAIL midrun_idle: got %h expected %h", {obs, instr_ready}, {24'h0, 1'b1});
    end
    run_macro(0, 4'h9, 4'h8, 4'h7, 0, -1);
  endtask

  initial begin
    init_model();
    test_reset();
    test_passthrough();
    test_macro_basic();
    test_stall();
    test_selector();
    test_wrap();
    test_back_to_back();
    test_random_macros();
    test_watchdog();
    test_passthrough();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/ucode_sequencer.md
UCODE_SEQUENCER -- requirements
Module: ucode_sequencer

Interface
REQ-001 Parameter UPC_W, default 6, sets the micro-PC width and a ROM depth of 2**UPC_W.
REQ-002 Parameter MAX_UOPS, default 32, sets the micro-op watchdog limit per macro sequence.
REQ-003 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst  in  1  asynchronous, active-low reset.
REQ-005 Port: instr_valid  in  1  decoded instruction offered.
REQ-006 Port: instr_ready  out  1  sequencer accepts the instruction this cycle.
REQ-007 Port: opcode  in  8  decoded opcode; bit7=1 marks a microcoded macro, with opcode[3:0] as its entry index.
REQ-008 Port: macro_rd, macro_rs1, macro_rs2  in  4 each  architectural operands of the macro.
REQ-009 Port: pipe_stall  in  1  downstream cannot consume a micro-op this cycle.
REQ-010 Port: uop_valid  out  1  micro-op/passthrough op present on outputs.
REQ-011 Port: uop_op  out  8  operation to execute.
REQ-012 Port: uop_rd, uop_rs1, uop_rs2  out  4 each  register indices presented to the register file.
REQ-013 Port: uop_write  out  1  register write enable for this op.
REQ-014 Port: ucode_flag  out  1  selects the ghost register file in the register stage.
REQ-015 Port: ucode_err  out  1  sticky watchdog-abort flag.

Function
REQ-016 States: IDLE, PASS, ENTER, RUN, EXIT; encoding lives in the shared package.
REQ-017 instr_ready = 1 only in IDLE or PASS with pipe_stall=0; a handshake occurs when instr_valid&instr_ready.
REQ-018 On a handshake with opcode[7]=0, the sequencer presents the op on the next cycle (1-cycle latency) with ucode_flag=0, uop_write=1, and operands copied; the state is PASS.
REQ-019 On a handshake with opcode[7]=1, the sequencer latches the macro operands, loads upc from entry table[opcode[3:0]], and moves to ENTER.
REQ-020 ENTER lasts exactly 2 cycles, with ucode_flag=1 and uop_valid=0, so the register stage completes its shadow copy before any ghost write.
REQ-021 RUN: ucode_flag=1 and uop_valid=1; the ROM word fields are op, rd/rs1/rs2 selectors, write, and last.
REQ-022 Each operand selector chooses either a 4-bit literal ghost index or substitutes macro_rd/rs1/rs2.
REQ-023 In RUN, when pipe_stall=1 all uop_* outputs and upc hold; otherwise upc increments and the uop counter increments.
REQ-024 A ROM word with last=1, consumed with pipe_stall=0, moves the state to EXIT.
REQ-025 upc wraps modulo 2**UPC_W; wrap is not an error.
REQ-026 EXIT lasts 1 cycle with ucode_flag=0 and uop_valid=0, then goes to IDLE.
REQ-027 If the uop counter reaches MAX_UOPS without last, the sequencer sets ucode_err=1 (sticky) and goes to EXIT.
REQ-028 In PASS or IDLE with pipe_stall=1, the outputs hold and no new instruction is accepted.
REQ-029 In PASS, if no handshake occurs the state returns to IDLE and uop_valid drops.
REQ-030 uop_write is forced to 0 whenever uop_valid=0.

Reset
REQ-031 On rst=0, asynchronously: state=IDLE, upc=0, uop counter=0, and all outputs 0, including ucode_flag and ucode_err.
REQ-032 Reset asserted mid-sequence abandons the sequence; no EXIT cycle occurs.
REQ-033 Operation resumes on the first rising clk edge after rst returns to 1.

Structure
REQ-034 Shared package: state encoding, ROM word field widths/offsets, operand-selector codes, and the opcode[7] macro-marker constant.
REQ-035 One sub-module, ucode_rom: combinational 16-entry entry table plus a 2**UPC_W-word micro-op ROM, indexed by upc.

Verification
REQ-036 Passthrough: opcode=0x12, rd=3, rs1=4, rs2=5, no stall -> next cycle uop_valid=1, uop_rd=3, uop_rs1=4, uop_rs2=5, ucode_flag=0.
REQ-037 Macro with a 3-uop ROM sequence: opcode=0x81 -> 2 cycles ucode_flag=1 with uop_valid=0, then 3 uops, then 1 EXIT cycle with flag=0, then instr_ready=1.
REQ-038 Stall: pipe_stall=1 for 4 cycles during the 2nd uop -> uop_* stable for those 4 cycles and no uop skipped or duplicated.
REQ-039 Selector substitution: macro_rs1=9 with a ROM rs1 selector of "macro rs1" -> uop_rs1=9; a literal selector 0xE -> uop_rs1=14.
REQ-040 Watchdog: an entry pointing at a ROM loop with no last bit -> after 32 uops, ucode_err=1 and EXIT, and ucode_err stays 1 until reset.
REQ-041 Reset mid-RUN: rst=0 on the 2nd uop -> outputs 0 immediately (asynchronous), and state=IDLE after release.
